// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI register-interface
//               initiator: frame layout, command layout, controller states.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = 8;

  typedef struct packed {
    logic       is_write;
    logic [6:0] addr;
  } spi_cmd_t;

  typedef struct packed {
    spi_cmd_t                         cmd;
    logic [FRAME_BITS-CMD_BITS-1:0]   data;
  } spi_frame_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } ctrl_state_t;

  // Reads carry a zero data byte so the peripheral sees a well-defined frame.
  function automatic spi_frame_t build_frame(input logic       is_write,
                                             input logic [6:0] addr,
                                             input logic [7:0] wdata);
    spi_frame_t f;
    f.cmd.is_write = is_write;
    f.cmd.addr     = addr;
    f.data         = is_write ? wdata : 8'h00;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_clk_div
// Description : Free-running divider counting 0..CLK_DIV-1 while i_run is
//               high; emits a one-cycle tick on the terminal count and is
//               held cleared while i_run is low.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_tick
);

  localparam logic [7:0] c_LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_div_cnt;

  assign o_tick = i_run && (r_div_cnt == c_LAST);

  // Count while running, wrap on terminal count, clear when stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (!i_run || o_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_controller
// Description : Mode-0 SPI initiator. Accepts one register request via
//               valid/ready, shifts out {write, addr[6:0], data[7:0]} MSB
//               first with an active-high cs, and captures the second byte
//               from poci for reads.
//               Build option SPI_CTRL_READ_EN: when defined, read data is
//               captured and returned on rsp_valid/rsp_rdata; when undefined
//               the capture path is absent and the response outputs are 0.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       spi_clk,
  output logic       cs,
  output logic       pico,
  input  logic       poci
);

  ctrl_state_t           r_state;
  ctrl_state_t           w_state_nxt;
  logic                  w_tick;
  logic                  w_run;
  logic                  w_accept;
  logic                  w_fall;
  logic                  w_rise;
  logic                  w_shift_done;
  logic [FRAME_BITS-1:0] r_tx_shift;
  logic [3:0]            r_bit_cnt;
  logic                  r_sclk;

  assign w_run    = (r_state != IDLE);
  assign w_accept = req_valid && (r_state == IDLE);

  // In SHIFT the tick alternates between ending a high phase (fall) and
  // ending a low phase (rise). A low-phase tick with bit_cnt back at zero
  // means all 16 falls have happened and the frame is finished.
  assign w_fall       = (r_state == SHIFT) && w_tick && r_sclk;
  assign w_rise       = (r_state == SHIFT) && w_tick && !r_sclk && (r_bit_cnt != 4'd0);
  assign w_shift_done = (r_state == SHIFT) && w_tick && !r_sclk && (r_bit_cnt == 4'd0);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk    (sys_clk),
    .rst    (rst),
    .i_run  (w_run),
    .o_tick (w_tick)
  );

  // Next-state logic: every move after IDLE waits for the divider tick.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (req_valid)    w_state_nxt = SETUP;
      SETUP:   if (w_tick)       w_state_nxt = SHIFT;
      SHIFT:   if (w_shift_done) w_state_nxt = HOLD;
      HOLD:    if (w_tick)       w_state_nxt = GAP;
      GAP:     if (w_tick)       w_state_nxt = IDLE;
      default:                   w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Transmit shifter, bit counter and serial clock phase.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_tx_shift <= '0;
      r_bit_cnt  <= '0;
      r_sclk     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tx_shift <= build_frame(req_write, req_addr, req_wdata);
        r_bit_cnt  <= '0;
      end
      // First rising edge of the frame closes the SETUP phase.
      if ((r_state == SETUP) && w_tick) begin
        r_sclk <= 1'b1;
      end
      if (w_fall) begin
        r_sclk     <= 1'b0;
        r_tx_shift <= {r_tx_shift[FRAME_BITS-2:0], 1'b0};
        r_bit_cnt  <= r_bit_cnt + 4'd1;
      end
      if (w_rise) begin
        r_sclk <= 1'b1;
      end
    end
  end

`ifdef SPI_CTRL_READ_EN
  logic       r_is_write;
  logic [7:0] r_rx_shift;
  logic [7:0] r_rsp_rdata;
  logic       r_rsp_valid;

  // Capture poci on rising edges of the data byte; publish it leaving HOLD.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_is_write  <= 1'b0;
      r_rx_shift  <= '0;
      r_rsp_rdata <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_is_write <= req_write;
      end
      if (w_rise && r_bit_cnt[3]) begin
        r_rx_shift <= {r_rx_shift[6:0], poci};
      end
      if ((r_state == HOLD) && w_tick && !r_is_write) begin
        r_rsp_rdata <= r_rx_shift;
        r_rsp_valid <= 1'b1;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
`else
  logic w_unused_poci;
  assign w_unused_poci = poci;
  assign rsp_valid     = 1'b0;
  assign rsp_rdata     = 8'h00;
`endif

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign spi_clk   = r_sclk;
  assign cs        = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);
  assign pico      = ((r_state == SETUP) || (r_state == SHIFT)) && r_tx_shift[FRAME_BITS-1];

endmodule
`default_nettype wire

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- SPI initiator for the chip's register interface. It generates spi_clk, cs and pico, and drives the same 16-bit frame that the on-chip spi_frontend decodes.
- Lives in the test/FPGA-side harness and in the loopback bench.
- Accepts one register request at a time through a valid/ready port. It serializes a command byte and a data byte, and returns read data sampled on poci.

Parameters:
- CLK_DIV, 4, sys_clk cycles per spi_clk half-period (legal range 2..255).
- FRAME_BITS, 16, bits per transaction; fixed and taken from the package.

Ports:
- sys_clk  input  1  system clock; all state is clocked on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller idle and accepting a request.
- req_write  input  1  1 = register write, 0 = register read.
- req_addr  input  7  register address.
- req_wdata  input  8  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse: read data valid.
- rsp_rdata  output  8  captured read byte; held until the next read completes.
- busy  output  1  transaction in progress (equals ~req_ready).
- spi_clk  output  1  serial clock; idles low (mode 0).
- cs  output  1  chip select, active-high.
- pico  output  1  serial data to the peripheral, MSB first.
- poci  input  1  serial data from the peripheral.

Behaviour:
- Frame is {req_write, req_addr[6:0], data[7:0]}, MSB first.
  - Data byte is req_wdata for writes and 8'h00 for reads.
- Mode 0 timing:
  - pico changes only while spi_clk is low.
  - Peripheral samples pico on the spi_clk rising edge.
  - Controller samples poci on the spi_clk rising edge.
- Reset values: req_ready=1, busy=0, spi_clk=0, cs=0, pico=0, rsp_valid=0, rsp_rdata=8'h00, state=IDLE.
- Handshake and request capture:
  - Acceptance happens on a rising sys_clk edge with req_valid & req_ready.
  - req_write, req_addr and req_wdata are registered into tx_shift[15:0] at acceptance; later changes to these inputs have no effect.
  - req_ready is 1 only in IDLE.
- States:
  - IDLE: outputs at reset values, except that rsp_rdata holds its value. On acceptance go to SETUP.
  - SETUP: cs=1, pico=tx_shift[15], spi_clk=0, for CLK_DIV cycles. Then go to SHIFT.
  - SHIFT: 16 spi_clk periods, each CLK_DIV cycles high then CLK_DIV cycles low.
    - bit_cnt (4-bit) counts from 0 to 15.
    - On each rising spi_clk: rx_shift <= {rx_shift[6:0], poci} when bit_cnt >= 8.
    - On each falling spi_clk: tx_shift shifts left and bit_cnt increments.
    - After the 16th falling edge, go to HOLD; bit_cnt wraps to 0.
  - HOLD: cs=1, spi_clk=0, pico=0, for CLK_DIV cycles. Then go to GAP.
    - On this transition, for a read: rsp_rdata <= rx_shift and rsp_valid=1 for exactly one cycle.
  - GAP: cs=0 for CLK_DIV cycles (minimum deselect time). Then go to IDLE.
- Timing totals:
  - cs is high for exactly 34*CLK_DIV cycles.
  - req_ready returns 35*CLK_DIV cycles after the acceptance edge.
- Divider: one div_cnt counts 0..CLK_DIV-1. Every state change and every spi_clk edge occurs on the div_cnt terminal count.
- Writes never assert rsp_valid and leave rsp_rdata unchanged.
- Reset mid-transaction:
  - Outputs go to reset values immediately and asynchronously; cs drops without completing the frame.
  - Any pending response is discarded.
  - The first request after reset release is accepted normally.
- A request presented in the same cycle as rst is not accepted.

Optional Feature:
- Macro: SPI_CTRL_READ_EN.
- Defined: read capture, rsp_valid and rsp_rdata behave as above.
- Undefined:
  - rx_shift is not built.
  - rsp_valid is tied 0 and rsp_rdata is tied 8'h00.
  - Read requests still transmit a full 16-bit frame with data byte 8'h00.

Decomposition:
- Package spi_pkg:
  - typedef spi_cmd_t = packed struct {logic is_write; logic [6:0] addr}.
  - typedef spi_frame_t = packed struct {spi_cmd_t cmd; logic [7:0] data}.
  - localparam FRAME_BITS = 16 and CMD_BITS = 8.
  - enum ctrl_state_t {IDLE, SETUP, SHIFT, HOLD, GAP}.
- Sub-module spi_clk_div:
  - Holds div_cnt and emits a one-cycle tick on the terminal count.
  - Counting is gated by a run input and cleared while it is low.

Test Plan:
1. Write, CLK_DIV=4: req_write=1, addr=7'h2A, wdata=8'hC3 -> pico sequence 1,0101010,11000011 on rising spi_clk; spi_frontend shows is_write=1, addr=0x2A, wdata=0xC3; cs high for 136 cycles; req_ready returns 140 cycles after acceptance.
2. Read: req_write=0, addr=7'h05, poci model returns 8'hA5 on the second byte -> command byte 0x05, data byte 0x00 on pico; rsp_valid pulses exactly once with rsp_rdata=0xA5.
3. Back-to-back: req_valid held high with 3 writes -> each request accepted only in IDLE; cs low for ≥CLK_DIV cycles between frames; no dropped or duplicated frames.
4. Reset mid-frame: assert rst after the 5th spi_clk rise -> cs=0, spi_clk=0, pico=0 in the same cycle without waiting for a sys_clk edge; no rsp_valid; the next read returns correct data.
5. Divider corners: CLK_DIV=2 and CLK_DIV=255 with addr=7'h7F, wdata=8'hFF -> spi_clk high and low phases are exactly CLK_DIV cycles each; 16 rising edges per frame.
6. SPI_CTRL_READ_EN undefined, read request -> full frame still transmitted; rsp_valid stays 0 throughout.
